// File: rtl/coffee_select_ctrl.sv
// coffee_select_ctrl
//   Drink-selection sequencer for the front-panel display. Two push-buttons
//   step through four drink options, confirm starts a timed brew phase with a
//   blinking display, and inactivity returns the panel to a blanked idle.
//
//   Optional feature: define COFFEE_CANCEL_EN to let a btn_next press abort a
//   running brew (brew_abort pulse, return to IDLE). Without it brew_abort is
//   held at 0 and every button is ignored while brewing.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   btn_next       "next option" button level (already synchronised)
//   btn_ok         "confirm" button level (already synchronised)
//   sel[1:0]       option code to the seven-segment letter decoder
//   disp_en        display enable, 0 blanks the segments
//   drink[1:0]     last confirmed option
//   brew_start     one-cycle pulse in the first BREW cycle
//   brew_busy      high for every BREW cycle
//   brew_abort     one-cycle pulse when a brew is cancelled
//   state_dbg[1:0] IDLE=0, SELECT=1, BREW=2, DONE=3
module coffee_select_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BREW_CYCLES    = 500,
  parameter int BLINK_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_ok,
  output logic [1:0] sel,
  output logic       disp_en,
  output logic [1:0] drink,
  output logic       brew_start,
  output logic       brew_busy,
  output logic       brew_abort,
  output logic [1:0] state_dbg
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > BREW_CYCLES) ? TIMEOUT_CYCLES : BREW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BREW_LAST = CNT_W'(BREW_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_BREW   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic [1:0]       btn_q, btn_d;
  logic [1:0]       armed_q, armed_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       drink_q, drink_d;
  logic             disp_en_q, disp_en_d;
  logic             brew_start_q, brew_start_d;
  logic             brew_busy_q, brew_busy_d;
  logic             brew_abort_q, brew_abort_d;

  logic [1:0] btn, btn_rise;
  logic       next_e, ok_e, any_e;

  // Bit 0 = next, bit 1 = ok. A button only becomes "armed" once it has been
  // seen low after reset, so a button held through reset release cannot fire.
  assign btn      = {btn_ok, btn_next};
  assign btn_rise = btn & ~btn_q & armed_q;
  assign next_e   = btn_rise[0];
  assign ok_e     = btn_rise[1];
  assign any_e    = |btn_rise;
  assign btn_d    = btn;
  assign armed_d  = armed_q | ~btn;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blink_d      = blink_q;
    sel_d        = sel_q;
    drink_d      = drink_q;
    disp_en_d    = disp_en_q;
    brew_start_d = 1'b0;
    brew_abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d     = 2'd0;
        disp_en_d = 1'b0;
        if (any_e) begin
          // The waking press only opens the menu; it never advances sel.
          state_d   = S_SELECT;
          cnt_d     = '0;
          disp_en_d = 1'b1;
        end
      end

      S_SELECT: begin
        if (ok_e) begin
          // ok takes priority over a simultaneous next: sel is frozen.
          state_d      = S_BREW;
          drink_d      = sel_q;
          cnt_d        = '0;
          blink_d      = '0;
          disp_en_d    = 1'b1;
          brew_start_d = 1'b1;
        end else if (next_e) begin
          sel_d = sel_q + 2'd1;
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          sel_d     = 2'd0;
          disp_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREW: begin
`ifdef COFFEE_CANCEL_EN
        if (next_e) begin
          // Abort beats the BREW->DONE transition on the final brew cycle.
          state_d      = S_IDLE;
          cnt_d        = '0;
          sel_d        = 2'd0;
          disp_en_d    = 1'b0;
          brew_abort_d = 1'b1;
        end else
`endif
        if (cnt_q == BREW_LAST) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          disp_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (blink_q == BLK_LAST) begin
            blink_d   = '0;
            disp_en_d = ~disp_en_q;
          end else begin
            blink_d = blink_q + BLK_W'(1);
          end
        end
      end

      S_DONE: begin
        if (any_e || cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          sel_d     = 2'd0;
          disp_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Brew/done show the confirmed drink rather than the menu cursor.
    if (state_d == S_BREW || state_d == S_DONE) sel_d = drink_d;
    brew_busy_d = (state_d == S_BREW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      blink_q      <= '0;
      btn_q        <= 2'b00;
      armed_q      <= 2'b00;
      sel_q        <= 2'd0;
      drink_q      <= 2'd0;
      disp_en_q    <= 1'b0;
      brew_start_q <= 1'b0;
      brew_busy_q  <= 1'b0;
      brew_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      btn_q        <= btn_d;
      armed_q      <= armed_d;
      sel_q        <= sel_d;
      drink_q      <= drink_d;
      disp_en_q    <= disp_en_d;
      brew_start_q <= brew_start_d;
      brew_busy_q  <= brew_busy_d;
      brew_abort_q <= brew_abort_d;
    end
  end

  assign sel        = sel_q;
  assign disp_en    = disp_en_q;
  assign drink      = drink_q;
  assign brew_start = brew_start_q;
  assign brew_busy  = brew_busy_q;
  assign brew_abort = brew_abort_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/coffee_select_ctrl.md
# coffee_select_ctrl

Sequencing controller for the coffee machine's drink-selection display. It turns two push-buttons into the 2-bit option code that feeds the S3 seven-segment letter decoder, and gates display blanking. It also runs the brew-timing phase and returns to idle on inactivity. It sits between the front-panel buttons and the display interface, and issues the brew start/abort pulses to the dispensing logic.

## Interface
- TIMEOUT_CYCLES, 1000, consecutive inactive cycles in SELECT or DONE before returning to IDLE (>=2)
- BREW_CYCLES, 500, duration of the brew phase in cycles (>=2)
- BLINK_CYCLES, 50, display toggle half-period during brew (>=1)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- btn_next  in  1  "next option" button, level, already synchronised
- btn_ok  in  1  "confirm" button, level, already synchronised
- sel  out  2  option code to the display decoder (0..3)
- disp_en  out  1  display enable; 0 = segments blanked
- drink  out  2  latched confirmed option
- brew_start  out  1  one-cycle pulse on entering BREW
- brew_busy  out  1  high for every cycle spent in BREW
- brew_abort  out  1  one-cycle abort pulse (see Configuration)
- state_dbg  out  2  current state encoding: IDLE=0, SELECT=1, BREW=2, DONE=3

## Operation
- Button edges: each button is registered once; `edge = btn & ~btn_q`. Only rising edges act. Held buttons do not repeat.
- **IDLE**: sel=0, disp_en=0, drink held. A rising edge on either button moves to SELECT with sel=0. That first edge does not increment sel.
- **SELECT**: disp_en=1.
  - next edge: sel <= sel+1 mod 4, so 3 wraps to 0.
  - ok edge: drink <= sel; move to BREW.
  - next and ok edges in the same cycle: ok wins and sel is unchanged.
  - Any edge clears the inactivity counter. TIMEOUT_CYCLES consecutive edge-free cycles move to IDLE.
- **BREW**: brew_busy=1 and sel=drink.
  - disp_en starts at 1 and toggles every BLINK_CYCLES cycles.
  - Buttons are ignored, except as described under Configuration.
  - After BREW_CYCLES cycles, move to DONE.
- **DONE**: sel=drink, disp_en=1 steady.
  - Any edge moves to IDLE.
  - TIMEOUT_CYCLES edge-free cycles also move to IDLE.
- Counters: one shared cycle counter, width $clog2(max(TIMEOUT_CYCLES,BREW_CYCLES)+1). It clears on every state change. A separate blink counter is sized by BLINK_CYCLES. Neither counter may overflow or wrap.
- Reset values: state=IDLE, sel=0, drink=0, disp_en=0, brew_start=0, brew_busy=0, brew_abort=0, btn_q registers=0. A button already high at reset release produces no edge until it is released and pressed again.
- Reset asserted mid-BREW returns all outputs to the reset values on the next clock edge. No brew_abort pulse is emitted.

## Timing
- Edge to state change: 1 cycle. An edge sampled at clock edge N produces the new state/sel/drink visible after clock edge N+1.
- brew_start is high exactly during the first BREW cycle, aligned with the first brew_busy cycle.
- brew_busy is high for exactly BREW_CYCLES consecutive cycles. DONE starts on the following cycle.
- Timeout: IDLE is entered after exactly TIMEOUT_CYCLES consecutive cycles in SELECT/DONE with no edge.
- Blink: disp_en is high for the first BLINK_CYCLES BREW cycles, then low for BLINK_CYCLES, and so on. Blink phase resets on each BREW entry.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- COFFEE_CANCEL_EN defined:
  - A btn_next rising edge during BREW pulses brew_abort for one cycle and moves to IDLE on the same clock.
  - drink keeps the aborted value.
  - If the edge coincides with the final BREW cycle, abort wins over the DONE transition.
- COFFEE_CANCEL_EN undefined: brew_abort is tied to 0, and all buttons are ignored in BREW.

## Test plan
Parameters for all scenarios: TIMEOUT_CYCLES=20, BREW_CYCLES=10, BLINK_CYCLES=2.
- Reset with both buttons held high, then release rst_n -> all outputs 0, state IDLE, no transition until a button is released and re-pressed.
- ok edge to wake, then 5 next edges -> SELECT, sel sequence 0,1,2,3,0,1 (wrap after 3); disp_en=1.
- sel=2, then next and ok rise in the same cycle -> drink=2, brew_start 1 cycle, brew_busy 10 cycles, disp_en pattern 1,1,0,0,1,1,0,0,1,1, then DONE with sel=2.
- SELECT with no edges for 20 cycles -> IDLE after exactly 20 cycles, sel=0, disp_en=0. An edge at cycle 19 restarts the count.
- COFFEE_CANCEL_EN defined, next edge at BREW cycle 4 -> brew_abort 1 cycle, IDLE next cycle. Repeating with the edge on BREW cycle 10 -> abort, never DONE.
- Undefined build, next edge during BREW -> ignored, brew_abort stays 0, DONE after 10 cycles. rst_n low at BREW cycle 5 -> outputs at reset values next cycle.
